fetch_branch_predictor: RTL

- Fetch-stage next-PC unit. Owns the PC register, a 16-entry 2-bit branch history table (BHT) and per-entry BTB valid bits.
- Drives the BTB read index each cycle and consumes the BTB predicted target. Resolves predictions against the decode-stage outcome.
- Issues the BTB write, the flush, and the redirect PC on a misprediction.
- Sits between the BTB/instruction memory and the IF/ID pipeline register.

---
 rtl/fetch_branch_predictor.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fetch_branch_predictor.sv
// Fetch-stage next-PC unit with a direct-mapped 2-bit branch history table.
// Owns the fetch PC, the BHT counters, the BTB valid bits and the prediction
// that travels with the instruction into decode; resolves that prediction
// against the decode-stage outcome and redirects fetch on a mispredict.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   stall              hazard stall; holds PC and the decode prediction slot
//   btb_target         BTB target read at btb_rd_idx
//   id_is_branch       decode holds a branch/jump
//   id_actual_taken    resolved direction from decode
//   id_actual_target   resolved target from decode
//   id_pc              PC of the instruction in decode
//   pc_curr            fetch PC to instruction memory
//   btb_rd_idx         BTB read index (pc_curr low bits)
//   btb_wen            BTB write enable (taken resolution)
//   btb_wr_idx         BTB write index (id_pc low bits)
//   btb_wr_target      BTB write data (id_actual_target)
//   pred_taken         combinational fetch-stage prediction
//   id_pred_taken      registered prediction for the instruction in decode
//   id_pred_target     registered predicted target for the instruction in decode
//   flush              mispredict; IF/ID is squashed at the next edge
module fetch_branch_predictor #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned PC_INC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [PC_W-1:0]   btb_target,
  input  logic              id_is_branch,
  input  logic              id_actual_taken,
  input  logic [PC_W-1:0]   id_actual_target,
  input  logic [PC_W-1:0]   id_pc,
  output logic [PC_W-1:0]   pc_curr,
  output logic [IDX_W-1:0]  btb_rd_idx,
  output logic              btb_wen,
  output logic [IDX_W-1:0]  btb_wr_idx,
  output logic [PC_W-1:0]   btb_wr_target,
  output logic              pred_taken,
  output logic              id_pred_taken,
  output logic [PC_W-1:0]   id_pred_target,
  output logic              flush
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [1:0]         bht_q [ENTRIES];
  logic [1:0]         bht_d [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic               id_pred_taken_q, id_pred_taken_d;
  logic [PC_W-1:0]    id_pred_target_q, id_pred_target_d;

  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic               resolve;
  logic               mispredict;

  assign rd_idx = pc_q[IDX_W-1:0];
  assign wr_idx = id_pc[IDX_W-1:0];

  // Prediction reads the pre-edge table contents; updates land at the edge.
  assign pred_taken = valid_q[rd_idx] & bht_q[rd_idx][1];

  // A stalled decode instruction resolves on its first unstalled cycle.
  assign resolve    = id_is_branch & ~stall;
  assign mispredict = resolve &
                      ((id_pred_taken_q != id_actual_taken) |
                       (id_pred_taken_q & id_actual_taken &
                        (id_pred_target_q != id_actual_target)));

  assign flush          = mispredict;
  assign btb_wen        = resolve & id_actual_taken;
  assign btb_wr_idx     = wr_idx;
  assign btb_wr_target  = id_actual_target;
  assign btb_rd_idx     = rd_idx;
  assign pc_curr        = pc_q;
  assign id_pred_taken  = id_pred_taken_q;
  assign id_pred_target = id_pred_target_q;

  // Next fetch PC: redirect, hold, predicted target, sequential.
  always_comb begin
    pc_d = pc_q + PC_W'(PC_INC);
    if (mispredict) begin
      pc_d = id_actual_taken ? id_actual_target : id_pc + PC_W'(PC_INC);
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = btb_target;
    end
  end

  // Saturating counter training and BTB valid tracking on resolution.
  always_comb begin
    bht_d   = bht_q;
    valid_d = valid_q;
    if (resolve) begin
      if (id_actual_taken) begin
        if (bht_q[wr_idx] != 2'b11) bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
        valid_d[wr_idx] = 1'b1;
      end else begin
        if (bht_q[wr_idx] != 2'b00) bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
      end
    end
  end

  // Prediction slot travelling into decode; squashed on a mispredict.
  always_comb begin
    id_pred_taken_d  = id_pred_taken_q;
    id_pred_target_d = id_pred_target_q;
    if (mispredict) begin
      id_pred_taken_d  = 1'b0;
      id_pred_target_d = '0;
    end else if (!stall) begin
      id_pred_taken_d  = pred_taken;
      id_pred_target_d = pred_taken ? btb_target : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q             <= '0;
      valid_q          <= '0;
      id_pred_taken_q  <= 1'b0;
      id_pred_target_q <= '0;
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      pc_q             <= pc_d;
      valid_q          <= valid_d;
      id_pred_taken_q  <= id_pred_taken_d;
      id_pred_target_q <= id_pred_target_d;
      bht_q            <= bht_d;
    end
  end

endmodule
